mmss_timer_ctrl: RTL and testbench

//  Run/stop/set controller for the mm:ss timekeeping chain (seconds mod-60 feeding minutes mod-60).

---
 rtl/mmss_pkg.sv | 18 +
 rtl/bcd_mod60_cnt.sv | 38 +++
 rtl/mmss_timer_ctrl.sv | 111 +++++++++++
 tb/tb_mmss_timer_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mmss_pkg.sv
// Shared definitions for the mm:ss timekeeping chain: FSM encodings and BCD limits.
package mmss_pkg;

  localparam int unsigned ONES_W = 4;
  localparam int unsigned TENS_W = 3;
  localparam int unsigned ST_W   = 2;

  typedef enum logic [ST_W-1:0] {
    ST_STOP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_t;

  localparam logic [ONES_W-1:0] BCD_MAX_ONES = 4'd9;
  localparam logic [TENS_W-1:0] BCD_MAX_TENS = 3'd5;

endpackage

// File: rtl/bcd_mod60_cnt.sv
// Two-digit BCD counter 00..59; clear beats increment, at_max flags 59.
module bcd_mod60_cnt
  import mmss_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [ONES_W-1:0] o_ones,
  output logic [TENS_W-1:0] o_tens,
  output logic              o_at_max
);

  logic [ONES_W-1:0] r_ones;
  logic [TENS_W-1:0] r_tens;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones <= '0;
      r_tens <= '0;
    end else if (i_clr) begin
      r_ones <= '0;
      r_tens <= '0;
    end else if (i_inc) begin
      if (r_ones == BCD_MAX_ONES) begin
        r_ones <= '0;
        r_tens <= (r_tens == BCD_MAX_TENS) ? '0 : r_tens + TENS_W'(1);
      end else begin
        r_ones <= r_ones + ONES_W'(1);
      end
    end
  end

  assign o_ones   = r_ones;
  assign o_tens   = r_tens;
  assign o_at_max = (r_ones == BCD_MAX_ONES) && (r_tens == BCD_MAX_TENS);

endmodule

// File: rtl/mmss_timer_ctrl.sv
// Run/stop/set controller: FSM, 1 s prescaler, seconds/minutes BCD counters and wrap strobes.
module mmss_timer_ctrl
  import mmss_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start_stop,
  input  logic              i_mode,
  input  logic              i_inc,
  input  logic              i_clear,
  output logic [ONES_W-1:0] o_sec_ones,
  output logic [TENS_W-1:0] o_sec_tens,
  output logic [ONES_W-1:0] o_min_ones,
  output logic [TENS_W-1:0] o_min_tens,
  output logic [ST_W-1:0]   o_state,
  output logic              o_sec_wrap,
  output logic              o_min_wrap
);

  localparam int unsigned PW = $clog2(CLK_DIV);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [PW-1:0]  r_presc;
  logic           r_sec_wrap;
  logic           r_min_wrap;
  logic           w_run;
  logic           w_tick;
  logic           w_presc_zero;
  logic           w_sec_inc;
  logic           w_min_inc;
  logic           w_sec_at_max;
  logic           w_min_at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_STOP;
    else     r_state <= w_state_nxt;
  end

  // start_stop outranks mode in STOP; SET states only react to mode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STOP: begin
        if (i_start_stop)  w_state_nxt = ST_RUN;
        else if (i_mode)   w_state_nxt = ST_SET_MIN;
      end
      ST_RUN:     if (i_start_stop) w_state_nxt = ST_STOP;
      ST_SET_MIN: if (i_mode)       w_state_nxt = ST_SET_SEC;
      ST_SET_SEC: if (i_mode)       w_state_nxt = ST_STOP;
      default:    w_state_nxt = ST_STOP;
    endcase
  end

  always_comb begin
    w_run        = 1'b0;
    w_tick       = 1'b0;
    w_presc_zero = 1'b0;
    w_sec_inc    = 1'b0;
    w_min_inc    = 1'b0;
    w_run        = (r_state == ST_RUN);
    w_tick       = w_run && (r_presc == PW'(CLK_DIV - 1));
    w_presc_zero = i_clear || ((r_state == ST_STOP) && (w_state_nxt == ST_SET_MIN));
    w_sec_inc    = w_tick || ((r_state == ST_SET_SEC) && i_inc);
    w_min_inc    = (w_tick && w_sec_at_max) || ((r_state == ST_SET_MIN) && i_inc);
  end

  // Prescaler holds outside RUN so a pause keeps the sub-second phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_presc <= '0;
    else if (w_presc_zero) r_presc <= '0;
    else if (w_run)        r_presc <= w_tick ? '0 : r_presc + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec_wrap <= 1'b0;
      r_min_wrap <= 1'b0;
    end else begin
      r_sec_wrap <= w_tick && w_sec_at_max && !i_clear;
      r_min_wrap <= w_tick && w_sec_at_max && w_min_at_max && !i_clear;
    end
  end

  bcd_mod60_cnt u_sec (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_sec_inc),
    .i_clr    (i_clear),
    .o_ones   (o_sec_ones),
    .o_tens   (o_sec_tens),
    .o_at_max (w_sec_at_max)
  );

  bcd_mod60_cnt u_min (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_min_inc),
    .i_clr    (i_clear),
    .o_ones   (o_min_ones),
    .o_tens   (o_min_tens),
    .o_at_max (w_min_at_max)
  );

  assign o_state    = r_state;
  assign o_sec_wrap = r_sec_wrap;
  assign o_min_wrap = r_min_wrap;

endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// Directed bench for mmss_timer_ctrl with CLK_DIV=4; inputs driven and outputs sampled on negedge.
module tb_mmss_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start_stop;
  logic        i_mode;
  logic        i_inc;
  logic        i_clear;
  logic [3:0]  o_sec_ones;
  logic [2:0]  o_sec_tens;
  logic [3:0]  o_min_ones;
  logic [2:0]  o_min_tens;
  logic [1:0]  o_state;
  logic        o_sec_wrap;
  logic        o_min_wrap;
  logic [15:0] obs_t;

  int n_cmp = 0;
  int n_err = 0;

  mmss_timer_ctrl #(.CLK_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start_stop (i_start_stop),
    .i_mode       (i_mode),
    .i_inc        (i_inc),
    .i_clear      (i_clear),
    .o_sec_ones   (o_sec_ones),
    .o_sec_tens   (o_sec_tens),
    .o_min_ones   (o_min_ones),
    .o_min_tens   (o_min_tens),
    .o_state      (o_state),
    .o_sec_wrap   (o_sec_wrap),
    .o_min_wrap   (o_min_wrap)
  );

  always #5 clk = ~clk;

  // Time read as BCD hex mmss, e.g. 16'h0159 = 01:59
  assign obs_t = {1'b0, o_min_tens, o_min_ones, 1'b0, o_sec_tens, o_sec_ones};

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    i_start_stop = 1'b1; @(negedge clk); i_start_stop = 1'b0;
  endtask

  task automatic pulse_mode();
    i_mode = 1'b1; @(negedge clk); i_mode = 1'b0;
  endtask

  task automatic pulse_inc();
    i_inc = 1'b1; @(negedge clk); i_inc = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clks(2); rst = 1'b0; clks(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; clks(2);
    n_cmp++; if (obs_t !== 16'h0000) begin n_err++; $display("FAIL reset_time: got %h expected %h", obs_t, 16'h0000); end
    n_cmp++; if (o_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", o_state, 0); end
    n_cmp++; if ({o_sec_wrap, o_min_wrap} !== 2'b00) begin n_err++; $display("FAIL reset_wraps: got %b expected %b", {o_sec_wrap, o_min_wrap}, 2'b00); end
    rst = 1'b0; clks(1);
    pulse_ss(); clks(148);
    n_cmp++; if (obs_t !== 16'h0037) begin n_err++; $display("FAIL run_to_37: got %h expected %h", obs_t, 16'h0037); end
    n_cmp++; if (o_state !== 2'd1) begin n_err++; $display("FAIL run_state: got %0d expected %0d", o_state, 1); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (obs_t !== 16'h0000) begin n_err++; $display("FAIL async_rst_time: got %h expected %h", obs_t, 16'h0000); end
    n_cmp++; if (o_state !== 2'd0) begin n_err++; $display("FAIL async_rst_state: got %0d expected %0d", o_state, 0); end
    clks(1); rst = 1'b0; clks(8);
    n_cmp++; if (obs_t !== 16'h0000) begin n_err++; $display("FAIL stop_after_rst: got %h expected %h", obs_t, 16'h0000); end
  endtask

  task automatic test_count();
    int wraps;
    int at;
    wraps = 0; at = 0;
    do_reset();
    pulse_ss();
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      if (o_sec_wrap) begin wraps++; at = i; end
    end
    n_cmp++; if (obs_t !== 16'h0100) begin n_err++; $display("FAIL count_240: got %h expected %h", obs_t, 16'h0100); end
    n_cmp++; if (wraps !== 1) begin n_err++; $display("FAIL count_wrap_n: got %0d expected %0d", wraps, 1); end
    n_cmp++; if (at !== 240) begin n_err++; $display("FAIL count_wrap_at: got %0d expected %0d", at, 240); end
  endtask

  task automatic test_rollover();
    int nw;
    nw = 0;
    do_reset();
    pulse_mode();
    n_cmp++; if (o_state !== 2'd2) begin n_err++; $display("FAIL roll_set_min: got %0d expected %0d", o_state, 2); end
    i_inc = 1'b1;
    repeat (59) begin @(negedge clk); if (o_sec_wrap || o_min_wrap) nw++; end
    i_inc = 1'b0;
    n_cmp++; if (obs_t !== 16'h5900) begin n_err++; $display("FAIL roll_min59: got %h expected %h", obs_t, 16'h5900); end
    pulse_mode();
    n_cmp++; if (o_state !== 2'd3) begin n_err++; $display("FAIL roll_set_sec: got %0d expected %0d", o_state, 3); end
    i_inc = 1'b1;
    repeat (59) begin @(negedge clk); if (o_sec_wrap || o_min_wrap) nw++; end
    i_inc = 1'b0;
    n_cmp++; if (obs_t !== 16'h5959) begin n_err++; $display("FAIL roll_5959: got %h expected %h", obs_t, 16'h5959); end
    pulse_mode();
    n_cmp++; if (o_state !== 2'd0) begin n_err++; $display("FAIL roll_back_stop: got %0d expected %0d", o_state, 0); end
    n_cmp++; if (nw !== 0) begin n_err++; $display("FAIL roll_set_no_wrap: got %0d expected %0d", nw, 0); end
    pulse_ss(); clks(3);
    n_cmp++; if (obs_t !== 16'h5959) begin n_err++; $display("FAIL roll_pre_tick: got %h expected %h", obs_t, 16'h5959); end
    clks(1);
    n_cmp++; if (obs_t !== 16'h0000) begin n_err++; $display("FAIL roll_0000: got %h expected %h", obs_t, 16'h0000); end
    n_cmp++; if ({o_sec_wrap, o_min_wrap} !== 2'b11) begin n_err++; $display("FAIL roll_wraps: got %b expected %b", {o_sec_wrap, o_min_wrap}, 2'b11); end
    clks(1);
    n_cmp++; if ({o_sec_wrap, o_min_wrap} !== 2'b00) begin n_err++; $display("FAIL roll_wraps_drop: got %b expected %b", {o_sec_wrap, o_min_wrap}, 2'b00); end
  endtask

  task automatic test_pause();
    do_reset();
    pulse_ss(); clks(5); pulse_ss();
    n_cmp++; if (obs_t !== 16'h0001) begin n_err++; $display("FAIL pause_time: got %h expected %h", obs_t, 16'h0001); end
    n_cmp++; if (o_state !== 2'd0) begin n_err++; $display("FAIL pause_state: got %0d expected %0d", o_state, 0); end
    clks(10);
    n_cmp++; if (obs_t !== 16'h0001) begin n_err++; $display("FAIL pause_hold: got %h expected %h", obs_t, 16'h0001); end
    pulse_ss(); clks(1);
    n_cmp++; if (obs_t !== 16'h0001) begin n_err++; $display("FAIL resume_early: got %h expected %h", obs_t, 16'h0001); end
    clks(1);
    n_cmp++; if (obs_t !== 16'h0002) begin n_err++; $display("FAIL resume_tick: got %h expected %h", obs_t, 16'h0002); end
  endtask

  task automatic test_set();
    int nw;
    nw = 0;
    do_reset();
    pulse_mode();
    pulse_inc(); pulse_inc(); pulse_inc();
    n_cmp++; if (obs_t !== 16'h0300) begin n_err++; $display("FAIL set_min3: got %h expected %h", obs_t, 16'h0300); end
    pulse_mode();
    i_inc = 1'b1;
    repeat (61) begin @(negedge clk); if (o_sec_wrap || o_min_wrap) nw++; end
    i_inc = 1'b0;
    n_cmp++; if (obs_t !== 16'h0301) begin n_err++; $display("FAIL set_sec61: got %h expected %h", obs_t, 16'h0301); end
    n_cmp++; if (nw !== 0) begin n_err++; $display("FAIL set_no_wrap: got %0d expected %0d", nw, 0); end
    pulse_mode();
    n_cmp++; if (o_state !== 2'd0) begin n_err++; $display("FAIL set_exit: got %0d expected %0d", o_state, 0); end
    pulse_inc();
    n_cmp++; if (obs_t !== 16'h0301) begin n_err++; $display("FAIL inc_in_stop: got %h expected %h", obs_t, 16'h0301); end
    i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;
    n_cmp++; if (obs_t !== 16'h0000) begin n_err++; $display("FAIL clear_stop: got %h expected %h", obs_t, 16'h0000); end
  endtask

  task automatic test_collision();
    do_reset();
    pulse_ss(); clks(236);
    n_cmp++; if (obs_t !== 16'h0059) begin n_err++; $display("FAIL coll_0059: got %h expected %h", obs_t, 16'h0059); end
    clks(3);
    i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;
    n_cmp++; if (obs_t !== 16'h0000) begin n_err++; $display("FAIL coll_time: got %h expected %h", obs_t, 16'h0000); end
    n_cmp++; if (o_sec_wrap !== 1'b0) begin n_err++; $display("FAIL coll_no_wrap: got %b expected %b", o_sec_wrap, 1'b0); end
    n_cmp++; if (o_state !== 2'd1) begin n_err++; $display("FAIL coll_state: got %0d expected %0d", o_state, 1); end
    clks(3);
    n_cmp++; if (obs_t !== 16'h0000) begin n_err++; $display("FAIL coll_presc_zeroed: got %h expected %h", obs_t, 16'h0000); end
    clks(1);
    n_cmp++; if (obs_t !== 16'h0001) begin n_err++; $display("FAIL coll_next_tick: got %h expected %h", obs_t, 16'h0001); end
  endtask

  task automatic test_priority();
    do_reset();
    i_start_stop = 1'b1; i_mode = 1'b1; @(negedge clk); i_start_stop = 1'b0; i_mode = 1'b0;
    n_cmp++; if (o_state !== 2'd1) begin n_err++; $display("FAIL prio_ss_wins: got %0d expected %0d", o_state, 1); end
    pulse_mode();
    n_cmp++; if (o_state !== 2'd1) begin n_err++; $display("FAIL mode_in_run: got %0d expected %0d", o_state, 1); end
    pulse_ss(); pulse_mode(); pulse_ss();
    n_cmp++; if (o_state !== 2'd2) begin n_err++; $display("FAIL ss_in_set: got %0d expected %0d", o_state, 2); end
    pulse_inc();
    i_clear = 1'b1; i_mode = 1'b1; @(negedge clk); i_clear = 1'b0; i_mode = 1'b0;
    n_cmp++; if (o_state !== 2'd3) begin n_err++; $display("FAIL clear_with_mode_state: got %0d expected %0d", o_state, 3); end
    n_cmp++; if (obs_t !== 16'h0000) begin n_err++; $display("FAIL clear_with_mode_time: got %h expected %h", obs_t, 16'h0000); end
  endtask

  initial begin
    rst = 1'b1; i_start_stop = 1'b0; i_mode = 1'b0; i_inc = 1'b0; i_clear = 1'b0;
    test_reset();
    test_count();
    test_rollover();
    test_pause();
    test_set();
    test_collision();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
